// File: rtl/work_transmit_pkg.sv
// Shared framing constants and types for the work serializer and its peers.
package work_transmit_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned BYTES_PER_WORK       = 64;
    localparam int unsigned WORK_BITS            = 512;
    localparam int unsigned HALF_BITS            = WORK_BITS / 2;
    localparam int unsigned BYTE_CNT_W           = $clog2(BYTES_PER_WORK);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic {
        WT_IDLE,
        WT_SEND
    } wt_state_e;

    typedef struct packed {
        logic [HALF_BITS-1:0] midstate;
        logic [HALF_BITS-1:0] data2;
    } work_t;

    // Baud counter width; never below one bit.
    function automatic int unsigned baud_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, stop bit.
// ready_o is high while idle and during the final cycle of the stop bit, so a
// start_i in that cycle chains the next byte with no idle gap.
module uart_tx_byte
    import work_transmit_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned       BAUD_W      = baud_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              tick_c;

    // State and datapath registers with synchronous reset to an idle-high line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    // Bit sequencer: the data register shifts right so bit 0 is always next.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        tick_c  = (baud_q == '0);

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start_i) begin
                    state_d = TX_START;
                    baud_d  = BAUD_RELOAD;
                    data_d  = data_i;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (tick_c) begin
                    state_d = TX_DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                    data_d  = {1'b0, data_q[7:1]};
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (tick_c) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = data_q[0];
                        data_d = {1'b0, data_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (tick_c) begin
                    if (start_i) begin
                        state_d = TX_START;
                        baud_d  = BAUD_RELOAD;
                        data_d  = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase

        ready_d = (state_d == TX_IDLE) || ((state_d == TX_STOP) && (baud_d == '0));
    end

    assign ready_o = ready_q;
    assign tx_o    = tx_q;

endmodule

// File: rtl/work_transmit.sv
// Serializes a 512-bit work unit (midstate then data2, MSB byte first) as 64
// back-to-back UART bytes.
module work_transmit
    import work_transmit_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 send,
    input  logic [HALF_BITS-1:0] midstate,
    input  logic [HALF_BITS-1:0] data2,
    output logic                 TxD,
    output logic                 busy,
    output logic                 done
);

    // The first byte goes straight to the byte transmitter on accept, so only
    // the remaining 63 bytes need to be held.
    localparam int unsigned                 REST_BITS = WORK_BITS - 8;
    localparam logic [BYTE_CNT_W-1:0]       LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORK - 1);

    wt_state_e             state_q, state_d;
    logic [REST_BITS-1:0]  shreg_q, shreg_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  done_q, done_d;
    logic                  tx_start_c;
    logic [7:0]            tx_byte_c;
    logic                  tx_ready;
    logic                  tx_line;
    work_t                 work_c;

    assign work_c.midstate = midstate;
    assign work_c.data2    = data2;

    // Frame-level registers with synchronous reset; reset beats a same-cycle send.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= WT_IDLE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
        end
    end

    // Accept, byte sequencing and completion; the next byte is handed over in
    // the last stop-bit cycle so bytes run with no gap.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        tx_start_c = 1'b0;
        tx_byte_c  = shreg_q[REST_BITS-1 -: 8];

        case (state_q)
            WT_IDLE: begin
                if (send) begin
                    state_d    = WT_SEND;
                    shreg_d    = REST_BITS'(work_c);
                    byte_cnt_d = '0;
                    tx_start_c = 1'b1;
                    tx_byte_c  = work_c[WORK_BITS-1 -: 8];
                end
            end
            WT_SEND: begin
                if (tx_ready) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = WT_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        shreg_d    = shreg_q << 8;
                        tx_start_c = 1'b1;
                    end
                end
            end
            default: state_d = WT_IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset_n(reset_n),
        .start_i(tx_start_c),
        .data_i (tx_byte_c),
        .ready_o(tx_ready),
        .tx_o   (tx_line)
    );

    assign TxD  = tx_line;
    assign busy = (state_q == WT_SEND);
    assign done = done_q;

endmodule

// File: tb/tb_work_transmit.sv
// Bench for work_transmit: table of work units sent back-to-back and decoded,
// plus reset corner sequences.
module tb_work_transmit;

    localparam int unsigned CPB       = 4;
    localparam int          FRAME_CYC = 640 * CPB;

    typedef struct packed {
        logic [255:0]      ms;
        logic [255:0]      d2;
        logic [63:0][7:0]  exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         send;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         TxD;
    logic         busy;
    logic         done;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [4];
    logic [7:0] pat_hi [4];
    logic [7:0] pat_lo [4];

    work_transmit #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .send    (send),
        .midstate(midstate),
        .data2   (data2),
        .TxD     (TxD),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Caller has already driven send and data before the accept edge.
    task automatic run_frame(input int v, input int inject_at, input bit chain, input int nv);
        logic [9:0] fr;
        int         bad_busy;
        int         bad_done;
        int         k;
        fr       = '0;
        bad_busy = 0;
        bad_done = 0;
        @(posedge clk);
        for (int j = 0; j < FRAME_CYC; j++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
            if (j == 0) check($sformatf("v%0d_start_latency", v), 16'(TxD), 16'd0);
            if ((j % CPB) == (CPB / 2)) begin
                k = j / CPB;
                fr[k % 10] = TxD;
                if ((k % 10) == 9)
                    check($sformatf("v%0d_byte%0d_frame", v, k / 10), 16'(fr),
                          16'({1'b1, vecs[v].exp[k / 10], 1'b0}));
            end
            if (j == inject_at) begin
                send     = 1'b1;
                midstate = ~vecs[v].ms;
                data2    = ~vecs[v].d2;
            end else begin
                send = 1'b0;
            end
        end
        check($sformatf("v%0d_busy_held", v), 16'(bad_busy), 16'd0);
        check($sformatf("v%0d_no_early_done", v), 16'(bad_done), 16'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", v), 16'(done), 16'd1);
        check($sformatf("v%0d_busy_in_done", v), 16'(busy), 16'd0);
        check($sformatf("v%0d_line_in_done", v), 16'(TxD), 16'd1);
        if (chain) begin
            send     = 1'b1;
            midstate = vecs[nv].ms;
            data2    = vecs[nv].d2;
        end else begin
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", v), 16'(done), 16'd0);
            check($sformatf("v%0d_idle_after", v), 16'(TxD), 16'd1);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        send     = 1'b0;
        midstate = '0;
        data2    = '0;

        pat_hi = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pat_lo = '{8'h01, 8'h23, 8'h45, 8'h67};

        vecs[0].ms = 256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;
        vecs[0].d2 = 256'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAFB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
        vecs[1].ms = {256{1'b1}};
        vecs[1].d2 = {256{1'b1}};
        vecs[2].ms = '0;
        vecs[2].d2 = '0;
        vecs[3].ms = {8{32'hDEADBEEF}};
        vecs[3].d2 = {8{32'h01234567}};
        for (int i = 0; i < 64; i++) begin
            vecs[0].exp[i] = (i < 32) ? 8'(i + 1) : 8'(8'hA0 + i - 32);
            vecs[1].exp[i] = 8'hFF;
            vecs[2].exp[i] = 8'h00;
            vecs[3].exp[i] = (i < 32) ? pat_hi[i % 4] : pat_lo[i % 4];
        end

        // Reset and quiet idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_txd", 16'(TxD), 16'd1);
            check("reset_busy", 16'(busy), 16'd0);
            check("reset_done", 16'(done), 16'd0);
        end

        // Table frames, chained back-to-back; busy send injected in the first
        send     = 1'b1;
        midstate = vecs[0].ms;
        data2    = vecs[0].d2;
        for (int v = 0; v < 4; v++)
            run_frame(v, (v == 0) ? 99 : -1, (v < 3), (v < 3) ? v + 1 : 0);

        // Reset and send in the same cycle
        reset_n  = 1'b0;
        send     = 1'b1;
        midstate = vecs[0].ms;
        data2    = vecs[0].d2;
        @(negedge clk);
        check("rst_send_busy", 16'(busy), 16'd0);
        check("rst_send_txd", 16'(TxD), 16'd1);
        reset_n = 1'b1;
        send    = 1'b0;
        @(negedge clk);
        check("rst_send_not_accepted", 16'(busy), 16'd0);
        check("rst_send_line_idle", 16'(TxD), 16'd1);

        // Mid-frame reset during byte 17 (0x12), data bit 3 (a zero)
        send = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 697; j++) begin
            @(negedge clk);
            send = 1'b0;
        end
        check("pre_reset_bit", 16'(TxD), 16'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_txd", 16'(TxD), 16'd1);
        check("midreset_busy", 16'(busy), 16'd0);
        check("midreset_done", 16'(done), 16'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("midreset_stays_idle", 16'(TxD), 16'd1);
        send     = 1'b1;
        midstate = vecs[0].ms;
        data2    = vecs[0].d2;
        run_frame(0, -1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/work_transmit.md
# work_transmit

Serializes one 512-bit work unit (256-bit midstate plus 256-bit data2) onto an async serial line as 64 UART bytes. Byte order and framing match what the cluster's work receiver expects. A hub uses it to re-time and forward work to external miner ports, and benches use it as the host-side driver for miner and hub top levels. It is the transmit-side counterpart of the workdata receive path.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit; 868 gives 115200 baud at 100 MHz (2x DCM output). Legal range is ≥ 2.

Ports:
- clk  in  1  single clock; all logic runs on its rising edge (hash_clk at the hub).
- reset_n  in  1  synchronous, active-low reset.
- send  in  1  one-cycle request; accepted only when busy = 0.
- midstate  in  256  work midstate; sampled on the accept cycle.
- data2  in  256  work data2; sampled on the accept cycle.
- TxD  out  1  UART line, idle high.
- busy  out  1  high from the cycle after accept until the last stop bit ends.
- done  out  1  one-cycle pulse when the frame completes.

## Operation
- Accept: send = 1 while busy = 0 latches {midstate, data2} into a 512-bit shift register. The byte counter and bit counter are cleared.
- send while busy = 1 is ignored. It is neither queued nor flagged. Inputs may change freely after the accept cycle.
- Byte order: midstate[255:248] goes first, then the next-lower byte, ending with data2[7:0] (64th byte). The register shifts left by 8 after each byte.
- Each byte is framed as: start bit (0), 8 data bits LSB first, stop bit (1). No parity. Bytes are sent back-to-back with no idle gap between a stop bit and the next start bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on accept.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA stays in DATA for 8 bit periods, bit counter 0..7, then goes to STOP.
  - STOP→START if the byte counter is below 63. The byte counter increments and the register shifts.
  - STOP→IDLE if the byte counter is 63. done pulses on this transition.
- The baud counter is a down-counter of width clog2(CLKS_PER_BIT). It reloads to CLKS_PER_BIT-1 on every bit boundary. The byte counter is 6 bits, and the terminal compare is at 63, so no wrap occurs.
- Reset (reset_n = 0 on a rising edge), in any state including mid-bit: go to IDLE, TxD = 1, busy = 0, done = 0, counters cleared. A truncated frame is not resumed.
- send and reset_n = 0 in the same cycle: reset wins and the frame is not accepted.

## Timing
- Reset values: TxD = 1, busy = 0, done = 0.
- Accept at cycle edge N: busy = 1 and TxD = 0 (start bit) from cycle N+1.
- Bit k of the frame (k = 0 is the start bit) occupies cycles N+1+k·CLKS_PER_BIT through N+(k+1)·CLKS_PER_BIT.
- A full frame is 640 bit periods (640·CLKS_PER_BIT cycles). The last stop bit ends at cycle N+640·CLKS_PER_BIT.
- done = 1 for exactly one cycle, N+640·CLKS_PER_BIT+1. busy = 0 in that same cycle, so a new send is accepted in the done cycle.
- TxD is registered, with no combinational path from inputs.
- Throughput: one work unit per 640·CLKS_PER_BIT+1 cycles with continuous send.

## Structure
- Shared package: CLKS_PER_BIT default, BYTES_PER_WORK = 64, and WORK_BITS = 512, so the hub, miner receiver and this block agree on framing.
- Sub-module uart_tx_byte: the START/DATA/STOP bit sequencer and baud counter, with a start/ready handshake and an 8-bit data input.
- work_transmit owns the 512-bit shift register, the byte counter, the busy/done logic and the IDLE state.

## Test plan
- Reset: CLKS_PER_BIT = 4. Hold reset_n = 0 for 3 cycles, then release → TxD = 1, busy = 0, done = 0. These hold with no send.
- Single frame: CLKS_PER_BIT = 4, midstate = 256'h0102…20, data2 = 256'hA0A1…BF, send for one cycle.
  - A bench UART decoder recovers bytes 01,02,…,20,A0,…,BF in order.
  - Every stop bit = 1.
  - done at accept+2561, busy low at that same cycle.
- Busy send ignored: pulse send again at accept+100 with different data → the frame contents are unchanged and only one done pulse occurs.
- Back-to-back: assert send in the done cycle → the next start bit begins the following cycle. There is no extra idle period, and the second frame decodes correctly.
- Mid-frame reset: reset_n = 0 during byte 17, data bit 3 → TxD = 1 and busy = 0 the next cycle. A following send produces a complete, correct frame starting at midstate[255:248].
- Edge data: all-0xFF then all-0x00 work → the decoder checks that the only 0s in the first frame are the start bits, that every byte reads 0x00 in the second, and that framing is intact.
